// File: rtl/lsu_align_if.sv
// Request/response and data-memory bus of the load/store alignment unit.
// The master side is the core together with the data memory; the slave side is lsu_align.
interface lsu_align_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              busy;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              err;
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    input  busy, resp_valid, resp_rdata, err, mem_read, mem_write, mem_addr, mem_wdata
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    output busy, resp_valid, resp_rdata, err, mem_read, mem_write, mem_addr, mem_wdata
  );
endinterface

// File: rtl/lsu_align.sv
// RV32I load/store alignment unit: sub-word stores become read-modify-write on a word memory.
// Define LSU_MISALIGNED_EN to execute misaligned accesses (split into LO/HI words) instead of rejecting them.
module lsu_align #(
  parameter int ADDR_W = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  lsu_align_if.slave bus
);

`ifdef LSU_MISALIGNED_EN
  localparam bit MISALIGNED_EN = 1'b1;
`else
  localparam bit MISALIGNED_EN = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, RD_LO, WR_LO, RD_HI, WR_HI, RESP} state_t;

  state_t            state, next_state;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [2:0]        funct3_q;
  logic [31:0]       wdata_q;
  logic              cross_q;
  logic [31:0]       lo_word, hi_word;
  logic              resp_valid_q, err_q;
  logic [31:0]       rdata_q;

  // Request decode, evaluated on the incoming request while IDLE.
  logic [1:0] req_off;
  logic       req_legal, req_misaligned, req_cross, req_reject, req_plain_sw;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    req_legal = 1'b0;
    req_off   = bus.req_addr[1:0];
    case (bus.req_funct3)
      3'b000, 3'b001, 3'b010: req_legal = 1'b1;
      3'b100, 3'b101:         req_legal = !bus.req_we;
      default:                req_legal = 1'b0;
    endcase
    req_misaligned = (bus.req_funct3[1:0] == 2'b01 && req_off[0]) ||
                     (bus.req_funct3[1:0] == 2'b10 && req_off != 2'b00);
    req_cross      = (bus.req_funct3[1:0] == 2'b10 && req_off != 2'b00) ||
                     (bus.req_funct3[1:0] == 2'b01 && req_off == 2'b11);
    req_reject     = !req_legal || (req_misaligned && !MISALIGNED_EN);
    req_plain_sw   = bus.req_we && bus.req_funct3 == 3'b010 && req_off == 2'b00;
  end

  // Lane datapath: the access is viewed as a 64-bit window {hi_word, lo_word} shifted by the offset.
  logic [1:0]        off;
  logic [3:0]        size_mask;
  logic [7:0]        lane_mask;
  logic [63:0]       store_lanes;
  logic [31:0]       lo_view, hi_view, load_window, load_data;
  logic [31:0]       merge_base, merge_data, write_word;
  logic [3:0]        merge_mask;
  logic [ADDR_W-1:0] lo_addr, hi_addr;

  always_comb begin
    off       = addr_q[1:0];
    size_mask = 4'b1111;
    case (funct3_q[1:0])
      2'b00:   size_mask = 4'b0001;
      2'b01:   size_mask = 4'b0011;
      default: size_mask = 4'b1111;
    endcase
    lane_mask   = {4'b0000, size_mask} << off;
    store_lanes = {32'h0, wdata_q} << {off, 3'b000};

    // The word being read this cycle is not registered yet, so the response uses it directly.
    lo_view     = (state == RD_LO) ? bus.mem_rdata : lo_word;
    hi_view     = (state == RD_HI) ? bus.mem_rdata : hi_word;
    load_window = 32'({hi_view, lo_view} >> {off, 3'b000});
    load_data   = load_window;
    case (funct3_q[1:0])
      2'b00:   load_data = {{24{load_window[7] & ~funct3_q[2]}}, load_window[7:0]};
      2'b01:   load_data = {{16{load_window[15] & ~funct3_q[2]}}, load_window[15:0]};
      default: load_data = load_window;
    endcase

    merge_base = (state == WR_HI) ? hi_word           : lo_word;
    merge_data = (state == WR_HI) ? store_lanes[63:32] : store_lanes[31:0];
    merge_mask = (state == WR_HI) ? lane_mask[7:4]     : lane_mask[3:0];
    write_word = merge_base;
    for (int k = 0; k < 4; k++) begin
      if (merge_mask[k]) write_word[8*k +: 8] = merge_data[8*k +: 8];
    end

    lo_addr = {addr_q[ADDR_W-1:2], 2'b00};
    hi_addr = lo_addr + {{(ADDR_W-3){1'b0}}, 3'b100};
  end

  logic              mem_read, mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;

  always_comb begin
    next_state = state;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    unique case (state)
      IDLE:  if (bus.req_valid) next_state = req_reject ? RESP : (req_plain_sw ? WR_LO : RD_LO);
      RD_LO: begin
        mem_read   = 1'b1;
        mem_addr   = lo_addr;
        next_state = we_q ? WR_LO : (cross_q ? RD_HI : RESP);
      end
      WR_LO: begin
        mem_write  = 1'b1;
        mem_addr   = lo_addr;
        mem_wdata  = write_word;
        next_state = cross_q ? RD_HI : RESP;
      end
      RD_HI: begin
        mem_read   = 1'b1;
        mem_addr   = hi_addr;
        next_state = we_q ? WR_HI : RESP;
      end
      WR_HI: begin
        mem_write  = 1'b1;
        mem_addr   = hi_addr;
        mem_wdata  = write_word;
        next_state = RESP;
      end
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // NOTE: state and datapath registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: data registers are reset too, so mem_wdata and resp_rdata never carry X after reset.
      addr_q       <= '0;
      we_q         <= 1'b0;
      funct3_q     <= '0;
      wdata_q      <= '0;
      cross_q      <= 1'b0;
      lo_word      <= '0;
      hi_word      <= '0;
      resp_valid_q <= 1'b0;
      err_q        <= 1'b0;
      rdata_q      <= '0;
    end else begin
      if (state == IDLE && bus.req_valid) begin
        addr_q   <= bus.req_addr;
        we_q     <= bus.req_we;
        funct3_q <= bus.req_funct3;
        wdata_q  <= bus.req_wdata;
        cross_q  <= req_cross;
      end
      if (state == RD_LO) lo_word <= bus.mem_rdata;
      if (state == RD_HI) hi_word <= bus.mem_rdata;
      resp_valid_q <= (next_state == RESP);
      // Only a rejected request jumps straight from IDLE to RESP.
      err_q        <= (state == IDLE) && (next_state == RESP);
      rdata_q      <= (next_state == RESP && state != IDLE && !we_q) ? load_data : '0;
    end
  end

  assign bus.busy       = (state != IDLE);
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = rdata_q;
  assign bus.err        = err_q;
  assign bus.mem_read   = mem_read;
  assign bus.mem_write  = mem_write;
  assign bus.mem_addr   = mem_addr;
  assign bus.mem_wdata  = mem_wdata;

endmodule

// File: tb/tb_lsu_align.sv
// Self-checking bench for lsu_align: directed cases then random requests against a byte-level memory model.
// Expectations follow the LSU_MISALIGNED_EN setting of the build.
module tb_lsu_align;
  localparam int ADDR_W = 32;
`ifdef LSU_MISALIGNED_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  lsu_align_if #(.ADDR_W(ADDR_W)) bus ();
  lsu_align #(.ADDR_W(ADDR_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  // 16-word data memory; word 15 doubles as 0xFFFFFFFC so wrapping accesses stay in range.
  logic [31:0] mem [16];
  logic [31:0] ref_mem [16];
  assign bus.mem_rdata = mem[bus.mem_addr[5:2]];
  always @(posedge clk) if (bus.mem_write) mem[bus.mem_addr[5:2]] <= bus.mem_wdata;

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
  } ev_t;
  ev_t exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_word(input int idx, input logic [31:0] v);
    ref_mem[idx] = v;
    mem[idx] <= v;
  endtask

  task automatic init_mem();
    for (int i = 0; i < 16; i++) set_word(i, $urandom);
  endtask

  function automatic logic [7:0] ref_byte(input logic [31:0] a);
    return ref_mem[a[5:2]][8*a[1:0] +: 8];
  endfunction

  // Reference: byte-addressed semantics; produces the expected per-cycle strobe trace and response.
  task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, output logic exp_err, output logic [31:0] exp_rdata);
    int          size, nwords;
    bit          legal, misal;
    logic [31:0] base, v, wa;
    ev_t         ev;
    exp_q.delete();
    exp_err   = 1'b0;
    exp_rdata = '0;
    size  = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    legal = (f3 inside {3'b000, 3'b001, 3'b010}) || (!we && (f3 inside {3'b100, 3'b101}));
    misal = (int'(addr[1:0]) % size) != 0;
    if (!legal || (misal && !MIS_EN)) begin
      exp_err = 1'b1;
      return;
    end
    base   = {addr[31:2], 2'b00};
    nwords = (int'(addr[1:0]) + size > 4) ? 2 : 1;
    if (!we) begin
      for (int w = 0; w < nwords; w++) begin
        ev = '{1'b0, base + 32'(4 * w), 32'h0};
        exp_q.push_back(ev);
      end
      v = '0;
      for (int i = 0; i < size; i++) v[8*i +: 8] = ref_byte(addr + 32'(i));
      if (!f3[2] && size == 1) v = {{24{v[7]}}, v[7:0]};
      if (!f3[2] && size == 2) v = {{16{v[15]}}, v[15:0]};
      exp_rdata = v;
    end else begin
      for (int i = 0; i < size; i++) begin
        wa = addr + 32'(i);
        ref_mem[wa[5:2]][8*wa[1:0] +: 8] = wdata[8*i +: 8];
      end
      if (size == 4 && !misal) begin
        ev = '{1'b1, base, wdata};
        exp_q.push_back(ev);
      end else begin
        for (int w = 0; w < nwords; w++) begin
          wa = base + 32'(4 * w);
          ev = '{1'b0, wa, 32'h0};
          exp_q.push_back(ev);
          ev = '{1'b1, wa, ref_mem[wa[5:2]]};
          exp_q.push_back(ev);
        end
      end
    end
  endtask

  task automatic drive_req(input logic valid, input logic we, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wdata);
    bus.req_valid  = valid;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
  endtask

  // Entered and left on a falling edge; hold=1 keeps req_valid high with junk fields while busy.
  task automatic run_txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input bit hold,
                         output logic obs_err, output logic [31:0] obs_rdata, output int obs_lat);
    logic        exp_err;
    logic [31:0] exp_rdata;
    int          n;
    model(we, f3, addr, wdata, exp_err, exp_rdata);
    n = exp_q.size();
    check("idle_busy", 32'(bus.busy), 32'd0);
    drive_req(1'b1, we, f3, addr, wdata);
    @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < n; i++) begin
      if (hold) drive_req(1'b1, 1'($urandom), 3'($urandom), $urandom, $urandom);
      else      bus.req_valid = 1'b0;
      check("step_busy", 32'(bus.busy), 32'd1);
      check("step_resp_valid", 32'(bus.resp_valid), 32'd0);
      check("step_mem_read", 32'(bus.mem_read), 32'(!exp_q[i].wr));
      check("step_mem_write", 32'(bus.mem_write), 32'(exp_q[i].wr));
      check("step_mem_addr", bus.mem_addr, exp_q[i].addr);
      if (exp_q[i].wr) check("step_mem_wdata", bus.mem_wdata, exp_q[i].wdata);
      @(negedge clk);
    end
    bus.req_valid = 1'b0;
    obs_err   = bus.err;
    obs_rdata = bus.resp_rdata;
    obs_lat   = n + 1;
    check("resp_valid", 32'(bus.resp_valid), 32'd1);
    check("resp_err", 32'(bus.err), 32'(exp_err));
    check("resp_rdata", bus.resp_rdata, exp_rdata);
    check("resp_no_strobe", {30'd0, bus.mem_read, bus.mem_write}, 32'd0);
    @(negedge clk);
    check("after_busy", 32'(bus.busy), 32'd0);
    check("after_resp_valid", 32'(bus.resp_valid), 32'd0);
    for (int i = 0; i < 16; i++) check($sformatf("mem_word%0d", i), mem[i], ref_mem[i]);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic        e;
    logic [31:0] r, o0, o1, wd, a;
    int          lat, widx;
    bit          h;

    // Reset with a request pending: everything must read zero.
    rst_n = 1'b0;
    drive_req(1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
    init_mem();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rst_resp_rdata", bus.resp_rdata, 32'd0);
    check("rst_err", 32'(bus.err), 32'd0);
    check("rst_mem_read", 32'(bus.mem_read), 32'd0);
    check("rst_mem_write", 32'(bus.mem_write), 32'd0);
    check("rst_mem_addr", bus.mem_addr, 32'd0);
    check("rst_mem_wdata", bus.mem_wdata, 32'd0);
    bus.req_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);

    // Signed and unsigned byte load from the top lane.
    set_word(4, 32'h8899AABB);
    run_txn(1'b0, 3'b000, 32'h13, 32'h0, 1'b0, e, r, lat);
    check("lb_rdata", r, 32'hFFFFFF88);
    check("lb_latency", 32'(lat), 32'd2);
    run_txn(1'b0, 3'b100, 32'h13, 32'h0, 1'b0, e, r, lat);
    check("lbu_rdata", r, 32'h00000088);

    // Byte store as read-modify-write.
    set_word(8, 32'h11223344);
    run_txn(1'b1, 3'b000, 32'h21, 32'h000000AB, 1'b0, e, r, lat);
    check("sb_err", 32'(e), 32'd0);
    check("sb_latency", 32'(lat), 32'd3);
    check("sb_word", mem[8], 32'h1122AB44);

    // Misaligned word load across two words.
    set_word(0, 32'hDDCCBBAA);
    set_word(1, 32'h44332211);
    run_txn(1'b0, 3'b010, 32'h2, 32'h0, 1'b0, e, r, lat);
    if (MIS_EN) begin
      check("lw_split_rdata", r, 32'h2211DDCC);
      check("lw_split_latency", 32'(lat), 32'd3);
    end else begin
      check("lw_mis_err", 32'(e), 32'd1);
      check("lw_mis_latency", 32'(lat), 32'd1);
    end

    // Misaligned word store wrapping past the top of the address space.
    o0 = ref_mem[15];
    o1 = ref_mem[0];
    run_txn(1'b1, 3'b010, 32'hFFFFFFFD, 32'hCAFEBABE, 1'b0, e, r, lat);
    if (MIS_EN) begin
      check("sw_wrap_latency", 32'(lat), 32'd5);
      check("sw_wrap_lo", mem[15], {24'hFEBABE, o0[7:0]});
      check("sw_wrap_hi", mem[0], {o1[31:8], 8'hCA});
    end else begin
      check("sw_mis_err", 32'(e), 32'd1);
      check("sw_mis_untouched", mem[15], o0);
    end

    // Illegal codes and an aligned word store at the top word.
    run_txn(1'b0, 3'b011, 32'h4, 32'h0, 1'b0, e, r, lat);
    check("illegal_011_err", 32'(e), 32'd1);
    run_txn(1'b1, 3'b101, 32'h4, 32'h1234, 1'b0, e, r, lat);
    check("illegal_shu_err", 32'(e), 32'd1);
    run_txn(1'b1, 3'b010, 32'hFFFFFFFC, 32'h5A5A0F0F, 1'b1, e, r, lat);
    check("sw_top_latency", 32'(lat), 32'd2);

    // Reset in the middle of a store with req_valid held high throughout.
    o0 = ref_mem[0];
    o1 = ref_mem[1];
    wd = $urandom;
    if (MIS_EN) begin
      drive_req(1'b1, 1'b1, 3'b010, 32'h1, wd);
      @(posedge clk);
      @(negedge clk);
      check("abort_rd_lo", 32'(bus.mem_read), 32'd1);
      @(negedge clk);
      check("abort_wr_lo", 32'(bus.mem_write), 32'd1);
      @(negedge clk);
      check("abort_rd_hi_addr", bus.mem_addr, 32'h4);
    end else begin
      o1 = ref_mem[8];
      drive_req(1'b1, 1'b1, 3'b000, 32'h21, wd);
      @(posedge clk);
      @(negedge clk);
      check("abort_rd_lo", 32'(bus.mem_read), 32'd1);
    end
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_strobes", {30'd0, bus.mem_read, bus.mem_write}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("abort_hold_write", 32'(bus.mem_write), 32'd0);
    bus.req_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_after_busy", 32'(bus.busy), 32'd0);
    check("abort_after_resp", 32'(bus.resp_valid), 32'd0);
    check("abort_after_write", 32'(bus.mem_write), 32'd0);
    if (MIS_EN) begin
      check("abort_lo_written", mem[0], {wd[23:0], o0[7:0]});
      check("abort_hi_untouched", mem[1], o1);
    end else begin
      check("abort_word_untouched", mem[8], o1);
    end

    // Random traffic over words 0..8 and the top word.
    init_mem();
    @(negedge clk);
    for (int t = 0; t < 300; t++) begin
      widx = $urandom_range(0, 9);
      a = (widx == 9) ? 32'hFFFFFFFC : 32'(widx * 4);
      a[1:0] = 2'($urandom_range(0, 3));
      wd = $urandom;
      h  = 1'($urandom_range(0, 1));
      run_txn(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, wd, h, e, r, lat);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
